// File: rtl/raster_pkg.sv
// raster_pkg: shared definitions for the frame rasterizer.
//   state_e     - controller states IDLE/LATCH/DRAW/DONE
//   COLOR_W     - width of a {R,G,B} colour word
//   GRID_COLOR  - colour of grid-line pixels (RASTER_GRIDLINES_EN builds)
//   ON/OFF defaults - colours for set/clear cells
//   clog2()     - constant-time width helper (never returns 0)
package raster_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int COLOR_W = 24;

  localparam logic [COLOR_W-1:0] GRID_COLOR    = 24'h404040;
  localparam logic [COLOR_W-1:0] ON_COLOR_DEF  = 24'hFFFFFF;
  localparam logic [COLOR_W-1:0] OFF_COLOR_DEF = 24'h000000;

  // Bits needed to hold 0..value-1; at least 1 so a counter never collapses to 0 bits.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/frame_rasterizer_if.sv
// frame_rasterizer_if: back-buffer write port with ready/valid stall.
//   wr_en    master->slave  write valid
//   wr_addr  master->slave  pixel address
//   wr_color master->slave  {R,G,B}
//   wr_ready slave->master  write accepted this cycle when wr_en is high
interface frame_rasterizer_if
  import raster_pkg::*;
#(
  parameter int ADDR_W = 15
);

  logic               wr_en;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_color;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_color,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_color,
    output wr_ready
  );

endinterface

// File: rtl/raster_scan_counter.sv
// raster_scan_counter: row-major pixel walker over the cell grid.
//   clk, rst   clock and synchronous active-high reset
//   clear      return to pixel (0,0)
//   enable     advance one pixel (the current pixel has been accepted)
//   *_nxt      position the counter will hold after this clock edge
//              (px/py in pixels, col/row in cells, subx/suby inside a cell)
//   last       the current pixel is the final one of the frame
// Cell coordinates come from sub-counters that wrap every CELL_PX pixels,
// so no divider is needed.
module raster_scan_counter
  import raster_pkg::*;
#(
  parameter int  GRID_W  = 42,
  parameter int  GRID_H  = 32,
  parameter int  CELL_PX = 3,
  localparam int PXW     = clog2(GRID_W * CELL_PX),
  localparam int PYW     = clog2(GRID_H * CELL_PX),
  localparam int CW      = clog2(GRID_W),
  localparam int RW      = clog2(GRID_H),
  localparam int SW      = clog2(CELL_PX)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           enable,
  output logic [PXW-1:0] px_nxt,
  output logic [PYW-1:0] py_nxt,
  output logic [CW-1:0]  col_nxt,
  output logic [RW-1:0]  row_nxt,
  output logic [SW-1:0]  subx_nxt,
  output logic [SW-1:0]  suby_nxt,
  output logic           last
);

  localparam logic [PXW-1:0] PX_MAX  = PXW'(GRID_W * CELL_PX - 1);
  localparam logic [PYW-1:0] PY_MAX  = PYW'(GRID_H * CELL_PX - 1);
  localparam logic [CW-1:0]  COL_MAX = CW'(GRID_W - 1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(GRID_H - 1);
  localparam logic [SW-1:0]  SUB_MAX = SW'(CELL_PX - 1);

  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [SW-1:0]  subx_q, subx_d;
  logic [SW-1:0]  suby_q, suby_d;

  // Next-position logic: x sub-counter carries into col, end of row carries into y.
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    col_d  = col_q;
    row_d  = row_q;
    subx_d = subx_q;
    suby_d = suby_q;
    if (clear) begin
      px_d   = '0;
      py_d   = '0;
      col_d  = '0;
      row_d  = '0;
      subx_d = '0;
      suby_d = '0;
    end else if (enable) begin
      if (subx_q == SUB_MAX) begin
        subx_d = '0;
        if (col_q == COL_MAX) begin
          // End of a pixel row: x wraps, y steps.
          col_d = '0;
          px_d  = '0;
          py_d  = (py_q == PY_MAX) ? '0 : py_q + PYW'(1);
          if (suby_q == SUB_MAX) begin
            suby_d = '0;
            row_d  = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
          end else begin
            suby_d = suby_q + SW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
          px_d  = px_q + PXW'(1);
        end
      end else begin
        subx_d = subx_q + SW'(1);
        px_d   = px_q + PXW'(1);
      end
    end else begin
      px_d = px_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q   <= '0;
      py_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      subx_q <= '0;
      suby_q <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      col_q  <= col_d;
      row_q  <= row_d;
      subx_q <= subx_d;
      suby_q <= suby_d;
    end
  end

  assign px_nxt   = px_d;
  assign py_nxt   = py_d;
  assign col_nxt  = col_d;
  assign row_nxt  = row_d;
  assign subx_nxt = subx_d;
  assign suby_nxt = suby_d;
  assign last     = (px_q == PX_MAX) && (py_q == PY_MAX);

endmodule

// File: rtl/frame_rasterizer.sv
// frame_rasterizer: snapshots the game's cell bitmap and paints it pixel by
// pixel into the VGA back buffer, then requests a buffer swap.
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle pulse: rasterize the current frame_data
//   frame_data  cell bitmap, bit index = row*GRID_W + col, row 0 at the top
//   wr          back-buffer write port (master side of frame_rasterizer_if)
//   busy        high from LATCH through DONE
//   swap_req    one-cycle pulse once the last pixel has been accepted
// Build option: define RASTER_GRIDLINES_EN to paint the first pixel row and
// column of every cell in GRID_COLOR; write count and timing are unchanged.
// All outputs are registered. The address/colour registers load the pixel the
// scan counter will point at after the edge, so they always describe the pixel
// currently offered and only move when a write is accepted.
module frame_rasterizer
  import raster_pkg::*;
#(
  parameter int                 GRID_W    = 42,
  parameter int                 GRID_H    = 32,
  parameter int                 CELL_PX   = 3,
  parameter int                 FB_W      = 160,
  parameter int                 FB_H      = 120,
  parameter int                 X_OFF     = 17,
  parameter int                 Y_OFF     = 12,
  parameter int                 ADDR_W    = 15,
  parameter logic [COLOR_W-1:0] ON_COLOR  = ON_COLOR_DEF,
  parameter logic [COLOR_W-1:0] OFF_COLOR = OFF_COLOR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [GRID_W*GRID_H-1:0] frame_data,
  frame_rasterizer_if.master       wr,
  output logic                     busy,
  output logic                     swap_req
);

  localparam int NCELL  = GRID_W * GRID_H;
  localparam int PXW    = clog2(GRID_W * CELL_PX);
  localparam int PYW    = clog2(GRID_H * CELL_PX);
  localparam int CW     = clog2(GRID_W);
  localparam int RW     = clog2(GRID_H);
  localparam int SW     = clog2(CELL_PX);
  localparam int CELL_IW = clog2(NCELL);

  state_e               state_q, state_d;
  logic                 pending_q, pending_d;
  logic [NCELL-1:0]     snapshot_q, snapshot_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0]   wr_color_q, wr_color_d;
  logic                 busy_q, busy_d;
  logic                 swap_q, swap_d;

  logic                 accept_s;
  logic                 last_s;
  logic [PXW-1:0]       px_nxt_s;
  logic [PYW-1:0]       py_nxt_s;
  logic [CW-1:0]        col_nxt_s;
  logic [RW-1:0]        row_nxt_s;
  logic [SW-1:0]        subx_nxt_s;
  logic [SW-1:0]        suby_nxt_s;
  logic [CELL_IW-1:0]   cell_idx_s;
  logic                 cell_on_s;
  logic [ADDR_W-1:0]    pix_addr_s;
  logic [COLOR_W-1:0]   pix_color_s;

  // Frame-buffer size only matters to the integrator sizing ADDR_W.
  logic [ADDR_W:0]      fb_extent_unused;
  assign fb_extent_unused = (ADDR_W + 1)'(FB_W * FB_H);

  assign accept_s = wr_en_q && wr.wr_ready;

  raster_scan_counter #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .CELL_PX (CELL_PX)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == LATCH),
    .enable   (accept_s),
    .px_nxt   (px_nxt_s),
    .py_nxt   (py_nxt_s),
    .col_nxt  (col_nxt_s),
    .row_nxt  (row_nxt_s),
    .subx_nxt (subx_nxt_s),
    .suby_nxt (suby_nxt_s),
    .last     (last_s)
  );

  // Controller next state; a start seen while busy is remembered in pending.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (start || pending_q) begin
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        state_d   = DRAW;
        pending_d = pending_q | start;
      end
      DRAW: begin
        pending_d = pending_q | start;
        if (accept_s && last_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAW;
        end
      end
      DONE: begin
        // A start arriving now counts as pending: go straight back to LATCH.
        pending_d = 1'b0;
        if (pending_q || start) begin
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Snapshot, pixel lookup and the registered output values.
  always_comb begin
    if (state_q == LATCH) begin
      snapshot_d = frame_data;
    end else begin
      snapshot_d = snapshot_q;
    end

    // snapshot_d so the first pixel, loaded during LATCH, sees the new bitmap.
    cell_idx_s = CELL_IW'(int'(row_nxt_s) * GRID_W + int'(col_nxt_s));
    cell_on_s  = snapshot_d[cell_idx_s];
    pix_addr_s = ADDR_W'((Y_OFF + int'(py_nxt_s)) * FB_W + X_OFF + int'(px_nxt_s));

`ifdef RASTER_GRIDLINES_EN
    if ((subx_nxt_s == '0) || (suby_nxt_s == '0)) begin
      pix_color_s = GRID_COLOR;
    end else begin
      pix_color_s = cell_on_s ? ON_COLOR : OFF_COLOR;
    end
`else
    pix_color_s = cell_on_s ? ON_COLOR : OFF_COLOR;
`endif

    wr_en_d  = (state_d == DRAW);
    busy_d   = (state_d != IDLE);
    swap_d   = (state_d == DONE);
    if (state_d == DRAW) begin
      wr_addr_d  = pix_addr_s;
      wr_color_d = pix_color_s;
    end else begin
      wr_addr_d  = '0;
      wr_color_d = '0;
    end
  end

`ifndef RASTER_GRIDLINES_EN
  // Sub-cell position only selects grid lines.
  logic grid_pos_unused;
  assign grid_pos_unused = ^{subx_nxt_s, suby_nxt_s};
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      snapshot_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_color_q <= '0;
      busy_q     <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      snapshot_q <= snapshot_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_color_q <= wr_color_d;
      busy_q     <= busy_d;
      swap_q     <= swap_d;
    end
  end

  assign wr.wr_en    = wr_en_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_color = wr_color_q;
  assign busy        = busy_q;
  assign swap_req    = swap_q;

endmodule

// File: tb/tb_frame_rasterizer.sv
// tb_frame_rasterizer: scoreboard bench for frame_rasterizer.
// Expected pixel streams are pushed when a frame is requested and popped as
// the DUT's writes are accepted. Define RASTER_GRIDLINES_EN for both the RTL
// and this bench to exercise the grid-line build.
module tb_frame_rasterizer;

  localparam int NCELL   = 1344;
  localparam int NPIX    = 12096;
`ifdef RASTER_GRIDLINES_EN
  localparam int BIT0_ON = 4;
`else
  localparam int BIT0_ON = 9;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [NCELL-1:0] fdata;
  logic             busy;
  logic             swap_req;

  frame_rasterizer_if #(.ADDR_W(15)) bus ();

  frame_rasterizer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_data (fdata),
    .wr         (bus),
    .busy       (busy),
    .swap_req   (swap_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [38:0] sb[$];
  bit  rnd_ready = 1'b0;
  int  acc_cnt = 0, frame_acc = 0, swap_cnt = 0, on_cnt = 0, stall_cnt = 0;
  int  first_addr = 0, last_addr = 0;
  logic [23:0] col00, col11;
  bit  stall_prev = 1'b0, swap_prev = 1'b0, busy_after_swap = 1'b0;
  logic [38:0] held;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference image: row-major over the grid region, cell lookup by division.
  task automatic push_frame(input logic [NCELL-1:0] bmp);
    logic [23:0] c;
    int addr;
    for (int py = 0; py < 96; py++) begin
      for (int px = 0; px < 126; px++) begin
        c = bmp[(py / 3) * 42 + (px / 3)] ? 24'hFFFFFF : 24'h000000;
`ifdef RASTER_GRIDLINES_EN
        if ((px % 3 == 0) || (py % 3 == 0)) c = 24'h404040;
`endif
        addr = (12 + py) * 160 + 17 + px;
        sb.push_back({addr[14:0], c});
      end
    end
  endtask

  // Ready driver: constant high or randomly stalling (3 in 4 accept).
  always @(posedge clk) begin
    #1;
    bus.wr_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      acc_cnt    = 0;
      stall_prev = 1'b0;
      swap_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        chk_eq("stall_hold", {bus.wr_en, bus.wr_addr, bus.wr_color}, {1'b1, held});
      end
      if (bus.wr_en && bus.wr_ready) begin
        chk_eq("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk_eq("pix", {bus.wr_addr, bus.wr_color}, sb.pop_front());
        end
        if (acc_cnt == 0) begin
          first_addr = int'(bus.wr_addr);
          col00      = bus.wr_color;
        end
        if (acc_cnt == 127) col11 = bus.wr_color;
        last_addr = int'(bus.wr_addr);
        if (bus.wr_color == 24'hFFFFFF) on_cnt++;
        acc_cnt++;
      end
      stall_prev = bus.wr_en && !bus.wr_ready;
      if (stall_prev) stall_cnt++;
      held = {bus.wr_addr, bus.wr_color};
      if (swap_prev) begin
        chk_eq("swap_one_cycle", swap_req, 0);
        busy_after_swap = busy;
      end
      if (swap_req) begin
        swap_cnt++;
        frame_acc = acc_cnt;
        acc_cnt   = 0;
      end
      swap_prev = swap_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit check_timing);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (check_timing) begin
      @(negedge clk);
      chk_eq("wr_en_in_latch", bus.wr_en, 0);
      @(negedge clk);
      chk_eq("wr_en_first", bus.wr_en, 1);
    end
  endtask

  task automatic wait_swap(input int bound);
    int  s0;
    bit  seen;
    s0   = swap_cnt;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (swap_cnt != s0) seen = 1'b1;
    end
    chk_eq("swap_seen", seen, 1);
    tick();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 42; i++) fdata[i*32 +: 32] = $urandom;
  endtask

  initial begin
    int s0;
    logic [NCELL-1:0] d;
    rst   = 1'b1;
    start = 1'b0;
    fdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_eq("rst_wr_en", bus.wr_en, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_swap", swap_req, 0);
    chk_eq("rst_addr", bus.wr_addr, 0);
    chk_eq("rst_color", bus.wr_color, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single set cell in the top-left corner.
    fdata    = '0;
    fdata[0] = 1'b1;
    push_frame(fdata);
    on_cnt = 0;
    pulse_start(1'b1);
    wait_swap(13000);
    chk_eq("bit0_writes", frame_acc, NPIX);
    chk_eq("bit0_on_pixels", on_cnt, BIT0_ON);
    chk_eq("bit0_first_addr", first_addr, 1937);
    chk_eq("bit0_last_addr", last_addr, 17262);
    chk_eq("bit0_sb_drained", sb.size(), 0);

    // Random data under random back-pressure.
    rand_data();
    rnd_ready = 1'b1;
    stall_cnt = 0;
    push_frame(fdata);
    pulse_start(1'b1);
    wait_swap(20000);
    rnd_ready = 1'b0;
    chk_eq("rnd_writes", frame_acc, NPIX);
    chk_eq("rnd_stalls_seen", (stall_cnt > 0), 1);
    chk_eq("rnd_sb_drained", sb.size(), 0);

    // Snapshot isolation plus two mid-frame starts collapsing into one frame.
    rand_data();
    d = fdata;
    push_frame(d);
    pulse_start(1'b0);
    repeat (4) tick();
    fdata = ~d;
    repeat (100) tick();
    push_frame(fdata);
    pulse_start(1'b0);
    repeat (50) tick();
    pulse_start(1'b0);
    wait_swap(13000);
    chk_eq("snap_writes", frame_acc, NPIX);
    chk_eq("no_idle_gap", busy_after_swap, 1);
    s0 = swap_cnt;
    wait_swap(13000);
    chk_eq("extra_writes", frame_acc, NPIX);
    chk_eq("idle_after_extra", busy_after_swap, 0);
    repeat (20) tick();
    chk_eq("one_extra_only", swap_cnt - s0, 1);
    chk_eq("idle_busy", busy, 0);
    chk_eq("extra_sb_drained", sb.size(), 0);

    // Reset in the middle of a frame.
    rand_data();
    push_frame(fdata);
    pulse_start(1'b0);
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (acc_cnt >= 5000) break;
    end
    chk_eq("rst_point_reached", (acc_cnt >= 5000), 1);
    s0  = swap_cnt;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_eq("midrst_wr_en", bus.wr_en, 0);
    chk_eq("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk_eq("midrst_no_swap", swap_cnt - s0, 0);
    chk_eq("midrst_sb_flushed", sb.size(), 0);

    // Clean all-zero frame after the reset.
    fdata  = '0;
    on_cnt = 0;
    push_frame(fdata);
    pulse_start(1'b1);
    wait_swap(13000);
    chk_eq("zero_writes", frame_acc, NPIX);
    chk_eq("zero_on_pixels", on_cnt, 0);
    chk_eq("zero_first_addr", first_addr, 1937);
    chk_eq("zero_last_addr", last_addr, 17262);
    chk_eq("zero_one_swap", swap_cnt - s0, 1);
    chk_eq("zero_sb_drained", sb.size(), 0);

`ifdef RASTER_GRIDLINES_EN
    // All cells set: grid lines override, interior pixels stay on.
    fdata = '1;
    push_frame(fdata);
    pulse_start(1'b1);
    wait_swap(13000);
    chk_eq("grid_pix00", col00, 24'h404040);
    chk_eq("grid_pix11", col11, 24'hFFFFFF);
    chk_eq("grid_writes", frame_acc, NPIX);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
